// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback path between the execute/memory
// stages and the register file.
package wb_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot mask for a destination; x0 maps to an empty mask since it is never tracked.
  function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (rd != '0) begin
      mask = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    end
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, and a tie goes to
// whichever side was not granted most recently.
module rr_arbiter2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       fire,
  output logic [1:0] gnt
);

  wb_src_e r_lastGrant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_lastGrant == WB_SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Starting from LSU hands the very first tie to the ALU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastGrant <= WB_SRC_LSU;
    end else if (fire) begin
      r_lastGrant <= gnt[1] ? WB_SRC_LSU : WB_SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback controller: arbitrates ALU/LSU results onto a registered register
// file write port and tracks outstanding destinations for decode.
module regfile_writeback
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [REG_AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  output logic                lsu_ready,
  output logic                rf_wen,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0] busy,
  output logic                wb_err
);

  logic [1:0]          w_gnt;
  logic                w_fire;
  wb_req_t             w_aluReq;
  wb_req_t             w_lsuReq;
  wb_req_t             w_winReq;
  logic                w_commitHit;
  logic                w_issueFire;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_clrMask;
  logic [NUM_REGS-1:0] w_winMask;
  logic [NUM_REGS-1:0] w_busyNext;
  logic                w_winTracked;
  logic                w_errEvent;

  logic                r_wen;
  logic [REG_AW-1:0]   r_waddr;
  logic [XLEN-1:0]     r_wdata;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({lsu_valid, alu_valid}),
    .fire  (w_fire),
    .gnt   (w_gnt)
  );

  assign w_fire    = |w_gnt;
  assign alu_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];

  assign w_aluReq = '{rd: alu_rd, data: alu_data};
  assign w_lsuReq = '{rd: lsu_rd, data: lsu_data};
  assign w_winReq = w_gnt[1] ? w_lsuReq : w_aluReq;

  // A register whose commit sits on the write port right now is free after this edge.
  assign w_commitHit = r_wen && (r_waddr == issue_rd);
  assign issue_ready = (issue_rd == '0) || !r_busy[issue_rd] || w_commitHit;
  assign w_issueFire = issue_valid && issue_ready && (issue_rd != '0);

  assign w_setMask  = w_issueFire ? regMask(issue_rd) : '0;
  assign w_clrMask  = r_wen ? regMask(r_waddr) : '0;
  assign w_busyNext = (r_busy & ~w_clrMask) | w_setMask;

  // A result is legitimate if its destination is busy now or is being issued this cycle.
  assign w_winMask    = regMask(w_winReq.rd);
  assign w_winTracked = |(w_winMask & (r_busy | w_setMask));
  assign w_errEvent   = w_fire && (w_winReq.rd != '0) && !w_winTracked;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_fire) begin
      r_wen   <= (w_winReq.rd != '0);
      r_waddr <= w_winReq.rd;
      r_wdata <= w_winReq.data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      if (w_errEvent) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = r_busy;
  assign wb_err   = r_err;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a per-cycle reference model and
// hand-computed spot checks.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        wb_err;

  int cmpCount = 0;
  int errCount = 0;
  bit checkEn  = 1'b0;

  bit          mBusy [32];
  bit          mWen      = 1'b0;
  logic [4:0]  mWaddr    = '0;
  logic [31:0] mWdata    = '0;
  bit          mErr      = 1'b0;
  bit          mLastAlu  = 1'b0;

  bit          sGA, sGL, sIF, sFire;
  logic [4:0]  sRd;
  logic [31:0] sData;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .wb_err      (wb_err)
  );

  function automatic logic [31:0] busyVec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = mBusy[i];
    return v;
  endfunction

  function automatic bit expAluGrant();
    return alu_valid && (!lsu_valid || !mLastAlu);
  endfunction

  function automatic bit expLsuGrant();
    return lsu_valid && !expAluGrant();
  endfunction

  function automatic bit expIssueReady();
    return (issue_rd == 5'd0) || !mBusy[issue_rd] || (mWen && mWaddr == issue_rd);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input bit lV, input logic [4:0] lRd, input logic [31:0] lD,
                               input bit iV, input logic [4:0] iRd);
    alu_valid   = aV;
    alu_rd      = aRd;
    alu_data    = aD;
    lsu_valid   = lV;
    lsu_rd      = lRd;
    lsu_data    = lD;
    issue_valid = iV;
    issue_rd    = iRd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: applies the writeback rules once per clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mWen = 1'b0; mWaddr = '0; mWdata = '0; mErr = 1'b0; mLastAlu = 1'b0;
    end else begin
      sGA   = expAluGrant();
      sGL   = expLsuGrant();
      sIF   = issue_valid && expIssueReady() && (issue_rd != 5'd0);
      sFire = sGA || sGL;
      sRd   = sGA ? alu_rd : lsu_rd;
      sData = sGA ? alu_data : lsu_data;
      if (sFire && sRd != 5'd0 && !mBusy[sRd] && !(sIF && issue_rd == sRd)) mErr = 1'b1;
      if (mWen) mBusy[mWaddr] = 1'b0;
      if (sIF) mBusy[issue_rd] = 1'b1;
      mWen = sFire && (sRd != 5'd0);
      if (sFire) begin
        mWaddr   = sRd;
        mWdata   = sData;
        mLastAlu = sGA;
      end
    end
  end

  // Every mid-cycle, all outputs must agree with the model.
  always @(negedge clk) begin
    if (reset && checkEn) begin
      checkOutput("m_rf_wen",      {31'b0, rf_wen},      {31'b0, mWen});
      checkOutput("m_rf_waddr",    {27'b0, rf_waddr},    {27'b0, mWaddr});
      checkOutput("m_rf_wdata",    rf_wdata,             mWdata);
      checkOutput("m_busy",        busy,                 busyVec());
      checkOutput("m_wb_err",      {31'b0, wb_err},      {31'b0, mErr});
      checkOutput("m_alu_ready",   {31'b0, alu_ready},   {31'b0, expAluGrant()});
      checkOutput("m_lsu_ready",   {31'b0, lsu_ready},   {31'b0, expLsuGrant()});
      checkOutput("m_issue_ready", {31'b0, issue_ready}, {31'b0, expIssueReady()});
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    checkEn = 1'b1;
    checkOutput("rst_wen",  {31'b0, rf_wen}, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);
    checkOutput("rst_err",  {31'b0, wb_err}, 32'h0);

    // Issue x5 then write it from the ALU.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    tick();
    checkOutput("t1_busy_set", busy, 32'h0000_0020);
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1 checkOutput("t1_alu_ready", {31'b0, alu_ready}, 32'h1);
    tick();
    idle();
    checkOutput("t1_wen",   {31'b0, rf_wen}, 32'h1);
    checkOutput("t1_waddr", {27'b0, rf_waddr}, 32'd5);
    checkOutput("t1_wdata", rf_wdata, 32'h1234);
    checkOutput("t1_busy_hold", busy, 32'h0000_0020);
    tick();
    checkOutput("t1_busy_clr", busy, 32'h0);
    checkOutput("t1_err", {31'b0, wb_err}, 32'h0);

    // LSU write to x0 is accepted but dropped.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    #1 checkOutput("t3_lsu_ready", {31'b0, lsu_ready}, 32'h1);
    tick();
    idle();
    checkOutput("t3_wen",   {31'b0, rf_wen}, 32'h0);
    checkOutput("t3_wdata", rf_wdata, 32'hFFFF_FFFF);
    checkOutput("t3_busy",  busy, 32'h0);

    // Pre-issue x1..x5, then four cycles of ALU/LSU contention.
    for (int r = 1; r <= 5; r++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r));
      tick();
    end
    idle();
    checkOutput("t2_busy_pre", busy, 32'h0000_003E);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    #1 checkOutput("t2_g0_alu", {30'b0, lsu_ready, alu_ready}, 32'h1);
    tick();
    checkOutput("t2_w0", {rf_wdata[23:0], 3'b0, rf_waddr}, {24'h11, 8'd1});
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    #1 checkOutput("t2_g1_lsu", {30'b0, lsu_ready, alu_ready}, 32'h2);
    tick();
    checkOutput("t2_w1", {rf_wdata[23:0], 3'b0, rf_waddr}, {24'h22, 8'd2});
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    #1 checkOutput("t2_g2_alu", {30'b0, lsu_ready, alu_ready}, 32'h1);
    tick();
    checkOutput("t2_w2", {rf_wdata[23:0], 3'b0, rf_waddr}, {24'h33, 8'd3});
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    #1 checkOutput("t2_g3_lsu", {30'b0, lsu_ready, alu_ready}, 32'h2);
    tick();
    checkOutput("t2_w3", {rf_wdata[23:0], 3'b0, rf_waddr}, {24'h44, 8'd4});
    idle();
    tick();
    checkOutput("t2_busy_post", busy, 32'h0000_0020);

    // Re-issue x7 while its commit is on the write port: set wins.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    #1 checkOutput("t4_issue_ready", {31'b0, issue_ready}, 32'h1);
    checkOutput("t4_wen", {31'b0, rf_wen}, 32'h1);
    tick();
    checkOutput("t4_busy_kept", busy, 32'h0000_00A0);
    applyStimulus(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    checkOutput("t4_busy_clr", busy, 32'h0000_0020);
    checkOutput("t4_err", {31'b0, wb_err}, 32'h0);

    // Result for untracked x9 still writes and raises the sticky error.
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    idle();
    checkOutput("t5_waddr", {27'b0, rf_waddr}, 32'd9);
    checkOutput("t5_err",   {31'b0, wb_err}, 32'h1);
    repeat (3) tick();
    checkOutput("t5_err_sticky", {31'b0, wb_err}, 32'h1);

    // Asynchronous reset while a commit is on the port.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    idle();
    checkOutput("t6_pre_wen",  {31'b0, rf_wen}, 32'h1);
    checkOutput("t6_pre_busy", busy, 32'h0000_00A0);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6_rst_wen",   {31'b0, rf_wen}, 32'h0);
    checkOutput("t6_rst_waddr", {27'b0, rf_waddr}, 32'h0);
    checkOutput("t6_rst_wdata", rf_wdata, 32'h0);
    checkOutput("t6_rst_busy",  busy, 32'h0);
    checkOutput("t6_rst_err",   {31'b0, wb_err}, 32'h0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB, 1'b0, 5'd0);
    #1 checkOutput("t6_tie_alu", {30'b0, lsu_ready, alu_ready}, 32'h1);
    tick();
    checkOutput("t6_wdata_a", rf_wdata, 32'hA);
    checkOutput("t6_tie_lsu", {30'b0, lsu_ready, alu_ready}, 32'h2);
    tick();
    idle();
    checkOutput("t6_wdata_b", rf_wdata, 32'hB);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback controller that drives the register file's write port (`wen`/`waddr`/`wdata`) on behalf of two result producers: the ALU and the load/store unit. Arbitrates between the producers with valid/ready handshakes and registers the winning result for one cycle before the write. Keeps a pending-write scoreboard: decode marks a destination busy at issue, and the mark clears when the write commits. Sits between the execute/memory stages and `register_file`, and feeds hazard information back to decode.

## Interface
- `XLEN`, 32, data width
- `NUM_REGS`, 32, architectural registers; index width is log2(NUM_REGS) = 5

- `clk`  in  1  clock, all state updates on posedge
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`
- `issue_rd`  in  5  destination of the issuing instruction
- `issue_ready`  out  1  combinational: `issue_rd` may be issued this cycle
- `alu_valid`  in  1  ALU result available
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle
- `lsu_valid`, `lsu_rd`, `lsu_data`, `lsu_ready`: same as the ALU set, for the LSU
- `rf_wen`  out  1  registered write enable to the register file
- `rf_waddr`  out  5  registered write address
- `rf_wdata`  out  XLEN  registered write data
- `busy`  out  NUM_REGS  scoreboard; bit i = write to xi outstanding
- `wb_err`  out  1  sticky flag: a result arrived for a non-busy, nonzero register

## Operation
- **Accept.** A source fires when `valid && ready`. At most one source fires per cycle. The register file never back-pressures, so whenever any source is valid, exactly one source fires.
- **Arbitration (round-robin, 2-way).**
  - Only one source valid: that source is granted.
  - Both valid: the source not granted most recently is granted.
  - `last_grant` updates on every fire.
  - `last_grant` resets to LSU, so the ALU wins the first tie.
- **Ready outputs.** `alu_ready`/`lsu_ready` are combinational from the valids and `last_grant`. They are independent of `rd` and data.
- **Output stage.**
  - On fire, `rf_waddr`/`rf_wdata` load the fired rd/data at the next edge.
  - `rf_wen` loads 1 if the fired rd != 0, else 0. A write to x0 is accepted and silently dropped.
  - With no fire, `rf_wen` loads 0. `rf_waddr`/`rf_wdata` hold their values.
- **Scoreboard.**
  - Issue fire is `issue_valid && issue_ready && issue_rd != 0`; it sets `busy[issue_rd]`.
  - A commit (`rf_wen == 1`) clears `busy[rf_waddr]` at the same edge the register file writes.
  - Set and clear on the same register in the same cycle: set wins.
- **issue_ready.** High when any of the following holds:
  - `issue_rd == 0`
  - `!busy[issue_rd]`
  - `rf_wen && rf_waddr == issue_rd`, i.e. the commit frees the register this edge
- **wb_err.** Set at the edge after a fire whose rd != 0 and whose `busy[rd]` is 0 (with no same-cycle issue to that rd). Cleared only by reset. The write still proceeds.
- **Reset (asynchronous, mid-operation).**
  - `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `busy` = 0, `wb_err` = 0, `last_grant` = LSU.
  - In-flight results are lost; producers re-present them after reset.

## Timing
- Fire in cycle N produces `rf_wen`/`rf_waddr`/`rf_wdata` valid in cycle N+1. `register_file` writes at the end of N+1, and the value is readable in cycle N+2.
- `busy[rd]` drops at the end of N+1, aligned with the write. Consumers must not bypass from `rf_wdata`.
- Throughput: one write per cycle. With both sources continuously valid, grants alternate ALU, LSU, ALU, …
- Ready outputs, `issue_ready`, and the arbitration select are the only combinational paths. There is no path from `rf_*` back into the ready outputs.

## Structure
- Shared package `wb_pkg`:
  - `XLEN`, `NUM_REGS`, `REG_AW` = 5
  - enum `wb_src_e` {`WB_SRC_ALU`, `WB_SRC_LSU`}
  - struct `wb_req_t` {rd, data}
- Sub-module `rr_arbiter2`:
  - Inputs: `clk`, `reset`, `req[1:0]`, `fire`
  - Outputs: one-hot `gnt[1:0]`
  - Owns `last_grant`
- Top level holds the output register, scoreboard and error flag.

## Test plan
- Reset, then issue x5, then ALU result (rd=5, data=0x1234) → `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234 one cycle after fire; `busy[5]` falls at the same edge; `wb_err`=0.
- ALU and LSU both valid for 4 cycles (rd 1/2, both pre-issued) → grants ALU, LSU, ALU, LSU; each `ready` high exactly on its grant cycle.
- LSU result with rd=0 and data=0xFFFFFFFF → `lsu_ready`=1, `rf_wen` stays 0, `busy` unchanged.
- x7 busy; `issue_rd`=7 while the commit of x7 is on `rf_*` → `issue_ready`=1 and `busy[7]` remains 1 after the edge (set wins); a second result for x7 then clears it.
- ALU result for x9 with `busy[9]`=0 → write to x9 occurs and `wb_err` rises the next cycle, staying high until reset.
- Assert reset mid-stream with `rf_wen`=1 and `busy`=0x0000_00A0 → all outputs 0 asynchronously; after release, the first tie is granted to the ALU.
